note_sequencer: RTL and testbench

Pattern-driven controller for the sawtooth voice. Holds a small programmable table of (period, duration) steps, walks it in frame time, and issues period loads plus a gate to the wave generator: FP_PERIOD_OUT/en_out feed its FP_PERIOD_IN/en inputs, and gate drives the voice mute. Sits between the host/register interface that writes the pattern and the waveform datapath on BIT_CLK. Shares the generator's frame_sig strobe.

---
 rtl/note_sequencer_if.sv | 32 +++
 rtl/note_sequencer.sv | 141 ++++++++++++++
 tb/tb_note_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_sequencer_if.sv
// Host/pattern-control and wave-generator signals of the note sequencer.
interface note_sequencer_if #(
   parameter int DEPTH = 8,
   parameter int DUR_W = 8
);
   localparam int AW = $clog2(DEPTH);

   logic             frame_sig;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [6:0]       wr_period;
   logic [DUR_W-1:0] wr_dur;
   logic             start;
   logic             stop;
   logic             loop;
   logic [6:0]       FP_PERIOD_OUT;
   logic             en_out;
   logic             gate;
   logic             busy;
   logic [AW-1:0]    step;
   logic             done;

   modport master (
      output frame_sig, wr_en, wr_addr, wr_period, wr_dur, start, stop, loop,
      input  FP_PERIOD_OUT, en_out, gate, busy, step, done
   );

   modport slave (
      input  frame_sig, wr_en, wr_addr, wr_period, wr_dur, start, stop, loop,
      output FP_PERIOD_OUT, en_out, gate, busy, step, done
   );
endinterface

// File: rtl/note_sequencer.sv
// Pattern-driven note sequencer: walks a (period, duration) table in frame
// time and issues period loads and a gate to the sawtooth wave generator.
module note_sequencer #(
   parameter int DEPTH = 8,
   parameter int DUR_W = 8
) (
   input logic             BIT_CLK,
   input logic             RST_N,
   note_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

   state_t           state, state_nx;
   logic [6:0]       ram_period [DEPTH];
   logic [DUR_W-1:0] ram_dur    [DEPTH];
   logic [DUR_W-1:0] count, count_nx;
   logic [6:0]       period_q, period_nx;
   logic             en_q, en_nx;
   logic             gate_q, gate_nx;
   logic             busy_q, busy_nx;
   logic             done_q, done_nx;
   logic [AW-1:0]    step_q, step_nx;
   logic             end_pat;

   // Pattern table: writable in any state, cleared by reset.
   always_ff @(posedge BIT_CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ram_period[i] <= '0;
            ram_dur[i]    <= '0;
         end
      end else if (bus.wr_en) begin
         ram_period[bus.wr_addr] <= bus.wr_period;
         ram_dur[bus.wr_addr]    <= bus.wr_dur;
      end
   end

   // State and registered outputs.
   always_ff @(posedge BIT_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         count    <= '0;
         period_q <= 7'd48;
         en_q     <= 1'b0;
         gate_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         step_q   <= '0;
      end else begin
         state    <= state_nx;
         count    <= count_nx;
         period_q <= period_nx;
         en_q     <= en_nx;
         gate_q   <= gate_nx;
         busy_q   <= busy_nx;
         done_q   <= done_nx;
         step_q   <= step_nx;
      end
   end

   // Next-state and next-output logic; end-of-pattern and stop are applied
   // after the per-state decode so both share one exit path.
   always_comb begin
      state_nx  = state;
      count_nx  = count;
      period_nx = period_q;
      en_nx     = 1'b0;
      gate_nx   = gate_q;
      done_nx   = 1'b0;
      step_nx   = step_q;
      end_pat   = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx = LOAD;
               step_nx  = '0;
            end
         end
         LOAD: begin
            if (ram_dur[step_q] == '0) begin
               end_pat = 1'b1;
            end else begin
               if (ram_period[step_q] != '0) begin
                  period_nx = ram_period[step_q];
                  en_nx     = 1'b1;
                  gate_nx   = 1'b1;
               end else begin
                  gate_nx = 1'b0;
               end
               count_nx = ram_dur[step_q];
               state_nx = PLAY;
            end
         end
         PLAY: begin
            if (bus.frame_sig) begin
               count_nx = count - DUR_W'(1);
               if (count == DUR_W'(1)) begin
                  if (step_q == AW'(DEPTH - 1)) begin
                     end_pat = 1'b1;
                  end else begin
                     step_nx  = step_q + AW'(1);
                     state_nx = LOAD;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      if (end_pat) begin
         gate_nx = 1'b0;
         step_nx = '0;
         if (bus.loop && (ram_dur[0] != '0)) begin
            state_nx = LOAD;
         end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
         end
      end

      if (bus.stop) begin
         state_nx = IDLE;
         gate_nx  = 1'b0;
         step_nx  = '0;
         done_nx  = 1'b0;
         en_nx    = 1'b0;
      end

      busy_nx = (state_nx != IDLE);
   end

   assign bus.FP_PERIOD_OUT = period_q;
   assign bus.en_out        = en_q;
   assign bus.gate          = gate_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.step          = step_q;
endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: directed timing checks plus
// randomized patterns compared against a step-list model of the pattern.
module tb_note_sequencer;
   localparam int DEPTH = 8;
   localparam int DUR_W = 8;
   localparam int AW    = $clog2(DEPTH);

   logic BIT_CLK = 1'b0;
   logic RST_N   = 1'b0;

   note_sequencer_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();

   note_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
      .BIT_CLK (BIT_CLK),
      .RST_N   (RST_N),
      .bus     (bus.slave)
   );

   always #5 BIT_CLK = ~BIT_CLK;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // pattern image held by the bench
   int pat_per [DEPTH];
   int pat_dur [DEPTH];

   // model expectations
   int exp_per [$];
   int exp_frame [$];
   int exp_step [$];
   int gate_exp [$];
   int tot;

   // observations
   int got_per [$];
   int got_frame [$];
   int got_step [$];
   int done_cnt;
   int done_frame;
   int done_busy;
   int frames_sent;

   // Observe strobes and done pulses just after each active edge.
   always @(posedge BIT_CLK) begin
      #1;
      if (RST_N) begin
         if (bus.en_out) begin
            got_per.push_back(int'(bus.FP_PERIOD_OUT));
            got_frame.push_back(frames_sent);
            got_step.push_back(int'(bus.step));
         end
         if (bus.done) begin
            done_cnt++;
            done_frame = frames_sent;
            done_busy  = int'(bus.busy);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge BIT_CLK);
   endtask

   task automatic clear_mon();
      got_per.delete();
      got_frame.delete();
      got_step.delete();
      done_cnt    = 0;
      done_frame  = -1;
      done_busy   = -1;
      frames_sent = 0;
   endtask

   task automatic clear_pat();
      for (int i = 0; i < DEPTH; i++) begin
         pat_per[i] = 0;
         pat_dur[i] = 0;
      end
   endtask

   task automatic load_pattern();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge BIT_CLK);
         bus.wr_en     = 1'b1;
         bus.wr_addr   = AW'(i);
         bus.wr_period = 7'(pat_per[i]);
         bus.wr_dur    = DUR_W'(pat_dur[i]);
      end
      @(negedge BIT_CLK);
      bus.wr_en = 1'b0;
   endtask

   // Expected strobes/gates: walk the table as a list of steps, each lasting
   // dur frames; with looping, the list repeats every tot frames.
   task automatic build_expect(input int loopv, input int max_frames);
      int bper [$];
      int bframe [$];
      int bstep [$];
      int bgate [$];
      exp_per.delete();
      exp_frame.delete();
      exp_step.delete();
      gate_exp.delete();
      tot = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (pat_dur[i] == 0) break;
         if (pat_per[i] != 0) begin
            bper.push_back(pat_per[i]);
            bframe.push_back(tot);
            bstep.push_back(i);
         end
         for (int f = 0; f < pat_dur[i]; f++) bgate.push_back(pat_per[i] != 0 ? 1 : 0);
         tot += pat_dur[i];
      end
      if (loopv != 0 && tot > 0) begin
         for (int r = 0; r * tot <= max_frames; r++)
            for (int j = 0; j < bper.size(); j++)
               if (bframe[j] + r * tot <= max_frames) begin
                  exp_per.push_back(bper[j]);
                  exp_frame.push_back(bframe[j] + r * tot);
                  exp_step.push_back(bstep[j]);
               end
         for (int n = 0; n < max_frames; n++) gate_exp.push_back(bgate[n % tot]);
      end else begin
         exp_per   = bper;
         exp_frame = bframe;
         exp_step  = bstep;
         gate_exp  = bgate;
      end
   endtask

   // Start playback and feed frames every 10 cycles until done or budget.
   task automatic play(input int loopv, input int max_frames, input bit poke);
      clear_mon();
      @(negedge BIT_CLK);
      bus.loop  = loopv[0];
      bus.start = 1'b1;
      @(negedge BIT_CLK);
      bus.start = 1'b0;
      tick(3);
      while (done_cnt == 0 && frames_sent < max_frames) begin
         if (frames_sent < gate_exp.size())
            check_eq("gate_in_step", int'(bus.gate), gate_exp[frames_sent]);
         bus.frame_sig = 1'b1;
         if (poke && frames_sent == 1) bus.start = 1'b1;
         frames_sent++;
         @(negedge BIT_CLK);
         bus.frame_sig = 1'b0;
         bus.start     = 1'b0;
         tick(9);
      end
   endtask

   task automatic compare_run(input bit expect_done);
      int n;
      check_eq("strobe_count", got_per.size(), exp_per.size());
      n = (got_per.size() < exp_per.size()) ? got_per.size() : exp_per.size();
      for (int i = 0; i < n; i++) begin
         check_eq("strobe_period", got_per[i], exp_per[i]);
         check_eq("strobe_frame", got_frame[i], exp_frame[i]);
         check_eq("strobe_step", got_step[i], exp_step[i]);
      end
      if (expect_done) begin
         check_eq("done_count", done_cnt, 1);
         check_eq("done_frame", done_frame, tot);
         check_eq("done_busy", done_busy, 0);
         check_eq("end_busy", int'(bus.busy), 0);
         check_eq("end_step", int'(bus.step), 0);
         check_eq("end_gate", int'(bus.gate), 0);
      end else begin
         check_eq("loop_no_done", done_cnt, 0);
         check_eq("loop_busy", int'(bus.busy), 1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      bus.frame_sig = 1'b0;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_period = '0;
      bus.wr_dur    = '0;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.loop      = 1'b0;
      clear_pat();
      clear_mon();
      tick(2);
      check_eq("rst_period", int'(bus.FP_PERIOD_OUT), 48);
      check_eq("rst_en", int'(bus.en_out), 0);
      check_eq("rst_gate", int'(bus.gate), 0);
      check_eq("rst_busy", int'(bus.busy), 0);
      check_eq("rst_step", int'(bus.step), 0);
      check_eq("rst_done", int'(bus.done), 0);
      RST_N = 1'b1;
      tick(2);

      // empty table with loop set: single LOAD then done
      clear_mon();
      bus.loop  = 1'b1;
      bus.start = 1'b1;
      @(negedge BIT_CLK);
      bus.start = 1'b0;
      check_eq("empty_busy_k", int'(bus.busy), 1);
      check_eq("empty_done_k", int'(bus.done), 0);
      @(negedge BIT_CLK);
      check_eq("empty_done_k1", int'(bus.done), 1);
      check_eq("empty_busy_k1", int'(bus.busy), 0);
      @(negedge BIT_CLK);
      check_eq("empty_done_pulse", int'(bus.done), 0);
      check_eq("empty_no_strobe", got_per.size(), 0);
      bus.loop = 1'b0;

      // start latency with (48,3),(24,2),end
      clear_pat();
      pat_per[0] = 48; pat_dur[0] = 3;
      pat_per[1] = 24; pat_dur[1] = 2;
      pat_per[2] = 99; pat_dur[2] = 0;
      load_pattern();
      @(negedge BIT_CLK);
      bus.start = 1'b1;
      @(negedge BIT_CLK);
      bus.start = 1'b0;
      check_eq("lat_busy_k", int'(bus.busy), 1);
      check_eq("lat_en_k", int'(bus.en_out), 0);
      @(negedge BIT_CLK);
      check_eq("lat_en_k1", int'(bus.en_out), 1);
      check_eq("lat_period_k1", int'(bus.FP_PERIOD_OUT), 48);
      check_eq("lat_gate_k1", int'(bus.gate), 1);
      @(negedge BIT_CLK);
      check_eq("lat_en_k2", int'(bus.en_out), 0);
      bus.stop = 1'b1;
      @(negedge BIT_CLK);
      bus.stop = 1'b0;
      check_eq("stop_busy", int'(bus.busy), 0);
      check_eq("stop_gate", int'(bus.gate), 0);

      // same pattern played through, one-shot then looping
      build_expect(0, 0);
      play(0, tot + 4, 1'b1);
      compare_run(1'b1);
      build_expect(1, 12);
      play(1, 12, 1'b0);
      compare_run(1'b0);
      @(negedge BIT_CLK);
      bus.stop = 1'b1;
      @(negedge BIT_CLK);
      bus.stop = 1'b0;
      check_eq("loop_stop_busy", int'(bus.busy), 0);
      check_eq("loop_stop_gate", int'(bus.gate), 0);
      check_eq("loop_stop_step", int'(bus.step), 0);
      check_eq("loop_stop_done", int'(bus.done), 0);
      tick(2);
      check_eq("loop_stop_no_done", done_cnt, 0);
      bus.loop = 1'b0;

      // leading rest
      clear_pat();
      pat_per[0] = 0;  pat_dur[0] = 2;
      pat_per[1] = 30; pat_dur[1] = 1;
      load_pattern();
      build_expect(0, 0);
      play(0, tot + 4, 1'b0);
      compare_run(1'b1);

      // full table, one frame each: ends from the last entry
      for (int i = 0; i < DEPTH; i++) begin
         pat_per[i] = 10 + i;
         pat_dur[i] = 1;
      end
      load_pattern();
      build_expect(0, 0);
      play(0, tot + 4, 1'b0);
      compare_run(1'b1);

      // randomized tables
      for (int r = 0; r < 14; r++) begin
         int end_at;
         for (int i = 0; i < DEPTH; i++) begin
            pat_per[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 127));
            pat_dur[i] = int'($urandom_range(1, 3));
         end
         end_at = int'($urandom_range(0, DEPTH));
         if (end_at < DEPTH) pat_dur[end_at] = 0;
         load_pattern();
         if (r % 4 == 3) begin
            build_expect(1, 9);
            play(1, 9, r[0]);
            if (tot > 0) begin
               compare_run(1'b0);
               @(negedge BIT_CLK);
               bus.stop = 1'b1;
               @(negedge BIT_CLK);
               bus.stop = 1'b0;
               check_eq("rnd_stop_busy", int'(bus.busy), 0);
            end else begin
               compare_run(1'b1);
            end
            bus.loop = 1'b0;
         end else begin
            build_expect(0, 0);
            play(0, tot + 4, r[0]);
            compare_run(1'b1);
         end
      end

      // asynchronous reset while a note is sounding
      clear_pat();
      pat_per[0] = 48; pat_dur[0] = 3;
      pat_per[1] = 24; pat_dur[1] = 2;
      load_pattern();
      clear_mon();
      @(negedge BIT_CLK);
      bus.start = 1'b1;
      @(negedge BIT_CLK);
      bus.start = 1'b0;
      tick(3);
      check_eq("pre_rst_gate", int'(bus.gate), 1);
      @(posedge BIT_CLK);
      #2;
      RST_N = 1'b0;
      #1;
      check_eq("arst_gate", int'(bus.gate), 0);
      check_eq("arst_period", int'(bus.FP_PERIOD_OUT), 48);
      check_eq("arst_busy", int'(bus.busy), 0);
      check_eq("arst_step", int'(bus.step), 0);
      @(negedge BIT_CLK);
      RST_N = 1'b1;
      clear_pat();
      tick(1);

      // start and stop together from IDLE
      clear_mon();
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      @(negedge BIT_CLK);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check_eq("ss_busy", int'(bus.busy), 0);
      @(negedge BIT_CLK);
      check_eq("ss_busy_later", int'(bus.busy), 0);
      check_eq("ss_done", done_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
